// File: rtl/fsk_bit_decoder.sv
// fsk_bit_decoder: turns the cumulative per-tone tick counters of the FSK
// tone analyzer into bit-window decisions, frames them UART-style (start 0,
// DATA_BITS LSB-first, optional even parity, stop 1) and hands out bytes over
// a valid/ready interface.
// Optional feature: define FSK_DECODER_PARITY_EN to expect an even-parity
// symbol between the data bits and the stop bit.
module fsk_bit_decoder #(
    parameter int CLOCK_FREQUENCY         = 50000000,
    parameter int BAUD_RATE               = 1000,
    parameter int DECISION_MARGIN_PERCENT = 25,
    parameter int MIN_ACTIVE_PERCENT      = 50,
    parameter int DATA_BITS               = 8
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] f0_value,
    input  logic [31:0] f1_value,
    output logic [7:0]  data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        bit_strobe,
    output logic        bit_value,
    output logic        bit_erasure,
    output logic        frame_error,
    output logic        overrun
);

    localparam int          BIT_TICKS   = CLOCK_FREQUENCY / BAUD_RATE;
    localparam logic [31:0] LAST_TICK   = 32'(BIT_TICKS - 1);
    localparam logic [32:0] MIN_ACTIVE  = 33'(BIT_TICKS * MIN_ACTIVE_PERCENT / 100);
    localparam logic [39:0] BASE_SCALE  = 40'd100;
    localparam logic [39:0] WIN_SCALE   = 40'(100 + DECISION_MARGIN_PERCENT);
    localparam logic [3:0]  LAST_BIT    = 4'(DATA_BITS - 1);
    localparam int          ALIGN_SHIFT = 8 - DATA_BITS;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frameState_t;

    logic [31:0] windowCount_q;
    logic [31:0] prev0_q;
    logic [31:0] prev1_q;
    logic [31:0] delta0_q;
    logic [31:0] delta1_q;
    logic        windowEnd_q;

    logic        bitStrobe_q;
    logic        bitValue_q;
    logic        bitErasure_q;

    logic [32:0] activeSum_d;
    logic [39:0] score0_d;
    logic [39:0] score1_d;
    logic [39:0] beat0_d;
    logic [39:0] beat1_d;
    logic        decideValue_d;
    logic        decideErasure_d;

    frameState_t state_q;
    logic [7:0]  shift_q;
    logic [3:0]  bitIdx_q;
    logic        frameErr_q;
`ifdef FSK_DECODER_PARITY_EN
    logic        parity_q;
`endif
    logic [7:0]  data_q;
    logic        dataValid_q;
    logic        overrun_q;
    logic        frameErrorPulse_q;
    logic [7:0]  assembled_d;

    // Window slicer: counts BIT_TICKS cycles and captures the per-tone tick deltas at each window end.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            windowCount_q <= '0;
            prev0_q       <= '0;
            prev1_q       <= '0;
            delta0_q      <= '0;
            delta1_q      <= '0;
            windowEnd_q   <= 1'b0;
        end else if (!enable) begin
            windowCount_q <= '0;
            prev0_q       <= f0_value;
            prev1_q       <= f1_value;
            windowEnd_q   <= 1'b0;
        end else begin
            windowEnd_q <= 1'b0;
            if (windowCount_q == LAST_TICK) begin
                windowCount_q <= '0;
                delta0_q      <= f0_value - prev0_q;
                delta1_q      <= f1_value - prev1_q;
                prev0_q       <= f0_value;
                prev1_q       <= f1_value;
                windowEnd_q   <= 1'b1;
            end else begin
                windowCount_q <= windowCount_q + 32'd1;
            end
        end
    end

    // Symbol decision: too little tone energy or no clear winner by the margin means erasure.
    always_comb begin
        activeSum_d     = {1'b0, delta0_q} + {1'b0, delta1_q};
        score0_d        = {8'd0, delta0_q} * BASE_SCALE;
        score1_d        = {8'd0, delta1_q} * BASE_SCALE;
        beat0_d         = {8'd0, delta0_q} * WIN_SCALE;
        beat1_d         = {8'd0, delta1_q} * WIN_SCALE;
        decideValue_d   = 1'b0;
        decideErasure_d = 1'b1;
        if (activeSum_d >= MIN_ACTIVE) begin
            if (score1_d > beat0_d) begin
                decideValue_d   = 1'b1;
                decideErasure_d = 1'b0;
            end else if (score0_d > beat1_d) begin
                decideValue_d   = 1'b0;
                decideErasure_d = 1'b0;
            end
        end
    end

    // Registers the decision one cycle after the window end and emits the bit strobe.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            bitStrobe_q  <= 1'b0;
            bitValue_q   <= 1'b0;
            bitErasure_q <= 1'b0;
        end else if (!enable) begin
            bitStrobe_q <= 1'b0;
        end else begin
            bitStrobe_q <= windowEnd_q;
            if (windowEnd_q) begin
                bitValue_q   <= decideValue_d;
                bitErasure_q <= decideErasure_d;
            end
        end
    end

    // Right-align the received payload so unused upper bits read as zero.
    always_comb begin
        assembled_d = shift_q >> ALIGN_SHIFT;
    end

    // Frame FSM plus output byte register, handshake and overrun tracking.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q           <= IDLE;
            shift_q           <= '0;
            bitIdx_q          <= '0;
            frameErr_q        <= 1'b0;
`ifdef FSK_DECODER_PARITY_EN
            parity_q          <= 1'b0;
`endif
            data_q            <= '0;
            dataValid_q       <= 1'b0;
            overrun_q         <= 1'b0;
            frameErrorPulse_q <= 1'b0;
        end else begin
            frameErrorPulse_q <= 1'b0;
            if (dataValid_q && data_ready) begin
                dataValid_q <= 1'b0;
            end
            if (!enable) begin
                state_q <= IDLE;
            end else if (bitStrobe_q) begin
                case (state_q)
                    IDLE: begin
                        if (!bitValue_q && !bitErasure_q) begin
                            state_q    <= DATA;
                            bitIdx_q   <= '0;
                            frameErr_q <= 1'b0;
`ifdef FSK_DECODER_PARITY_EN
                            parity_q   <= 1'b0;
`endif
                        end
                    end
                    DATA: begin
                        shift_q <= {bitValue_q, shift_q[7:1]};
`ifdef FSK_DECODER_PARITY_EN
                        parity_q <= parity_q ^ bitValue_q;
`endif
                        if (bitErasure_q) begin
                            frameErr_q <= 1'b1;
                        end
                        if (bitIdx_q == LAST_BIT) begin
`ifdef FSK_DECODER_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end else begin
                            bitIdx_q <= bitIdx_q + 4'd1;
                        end
                    end
`ifdef FSK_DECODER_PARITY_EN
                    PARITY: begin
                        if (bitErasure_q || (bitValue_q != parity_q)) begin
                            frameErr_q <= 1'b1;
                        end
                        state_q <= STOP;
                    end
`endif
                    STOP: begin
                        state_q <= IDLE;
                        if (bitValue_q && !bitErasure_q && !frameErr_q) begin
                            if (dataValid_q && !data_ready) begin
                                overrun_q <= 1'b1;
                            end else begin
                                data_q      <= assembled_d;
                                dataValid_q <= 1'b1;
                            end
                        end else begin
                            frameErrorPulse_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data        = data_q;
    assign data_valid  = dataValid_q;
    assign bit_strobe  = bitStrobe_q;
    assign bit_value   = bitValue_q;
    assign bit_erasure = bitErasure_q;
    assign frame_error = frameErrorPulse_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_fsk_bit_decoder.sv
// tb_fsk_bit_decoder: directed frames into the FSK bit decoder with a byte
// scoreboard; the monitor pops expected bytes on every valid/ready transfer.
// Honours FSK_DECODER_PARITY_EN to add the parity symbol and parity cases.
module tb_fsk_bit_decoder;

    localparam int BIT_TICKS = 100;
`ifdef FSK_DECODER_PARITY_EN
    localparam int FRAME_SYMS = 11;
`else
    localparam int FRAME_SYMS = 10;
`endif

    logic        clock = 1'b0;
    logic        clear;
    logic        enable;
    logic [31:0] f0Value;
    logic [31:0] f1Value;
    logic [7:0]  data;
    logic        dataValid;
    logic        dataReady;
    logic        bitStrobe;
    logic        bitValue;
    logic        bitErasure;
    logic        frameError;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int strobeCount = 0;
    int erasureCount = 0;
    int frameErrCount = 0;
    int startCycle = 0;
    int firstValidCycle = 0;
    logic validSeen = 1'b0;
    logic [7:0] expQ[$];

    fsk_bit_decoder #(
        .CLOCK_FREQUENCY(1000),
        .BAUD_RATE(10),
        .DECISION_MARGIN_PERCENT(25),
        .MIN_ACTIVE_PERCENT(50),
        .DATA_BITS(8)
    ) dut (
        .clock(clock),
        .clear(clear),
        .enable(enable),
        .f0_value(f0Value),
        .f1_value(f1Value),
        .data(data),
        .data_valid(dataValid),
        .data_ready(dataReady),
        .bit_strobe(bitStrobe),
        .bit_value(bitValue),
        .bit_erasure(bitErasure),
        .frame_error(frameError),
        .overrun(overrun)
    );

    // Free-running 10-unit clock.
    always #5 clock = ~clock;

    // Cycle counter used for latency measurement.
    always @(posedge clock) cycleCount++;

    // Monitor: samples mid-cycle, counts strobes/erasures/frame errors and scores every byte transfer.
    always @(negedge clock) begin
        logic [7:0] expected;
        #2;
        if (clear) begin
            if (bitStrobe) strobeCount++;
            if (bitStrobe && bitErasure) erasureCount++;
            if (frameError) frameErrCount++;
            if (dataValid && !validSeen) begin
                validSeen = 1'b1;
                firstValidCycle = cycleCount;
            end
            if (dataValid && dataReady) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_byte got %h required no transfer", data);
                end else begin
                    expected = expQ.pop_front();
                    if (data !== expected) begin
                        errors++;
                        $display("[TB] FAIL byte_data got %h required %h", data, expected);
                    end
                end
            end
        end
    end

    // Compares one observed value against the bench's own expectation.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s got %0h required %0h", name, actual, required);
        end
    endtask

    // One bit window: adds the tone ticks mid-window so exactly one update lands in it.
    task automatic sendWindow(input int d0, input int d1);
        repeat (50) @(negedge clock);
        f0Value = f0Value + 32'(d0);
        f1Value = f1Value + 32'(d1);
        repeat (50) @(negedge clock);
    endtask

    task automatic sendSymbol(input logic v);
        if (v) sendWindow(0, 90);
        else   sendWindow(90, 0);
    endtask

    // Sends a full frame followed by one idle mark window.
    task automatic applyStimulus(input logic [7:0] b, input logic stopOne, input logic flipParity);
        sendSymbol(1'b0);
        for (int i = 0; i < 8; i++) sendSymbol(b[i]);
`ifdef FSK_DECODER_PARITY_EN
        sendSymbol((^b) ^ flipParity);
`else
        if (flipParity) begin
            $display("[TB] parity flip ignored without parity symbol");
        end
`endif
        sendSymbol(stopOne);
        sendSymbol(1'b1);
    endtask

    task automatic doReset(input logic [31:0] f0Init);
        @(negedge clock);
        clear = 1'b0;
        enable = 1'b0;
        dataReady = 1'b1;
        f0Value = f0Init;
        f1Value = 32'd0;
        repeat (3) @(negedge clock);
        strobeCount = 0;
        erasureCount = 0;
        frameErrCount = 0;
        validSeen = 1'b0;
        clear = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic startRun();
        enable = 1'b1;
        startCycle = cycleCount;
    endtask

    initial begin
        clear = 1'b1;
        enable = 1'b0;
        dataReady = 1'b1;
        f0Value = '0;
        f1Value = '0;

        // Reset state
        @(negedge clock);
        clear = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset_data", 32'(data), 32'h0);
        checkOutput("reset_data_valid", 32'(dataValid), 32'h0);
        checkOutput("reset_bit_strobe", 32'(bitStrobe), 32'h0);
        checkOutput("reset_bit_value", 32'(bitValue), 32'h0);
        checkOutput("reset_bit_erasure", 32'(bitErasure), 32'h0);
        checkOutput("reset_frame_error", 32'(frameError), 32'h0);
        checkOutput("reset_overrun", 32'(overrun), 32'h0);

        // Clean frame 0x5A with ready high
        $display("[TB] frame 0x5A");
        doReset(32'd0);
        startRun();
        expQ.push_back(8'h5A);
        applyStimulus(8'h5A, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("5a_delivered", 32'(expQ.size()), 32'd0);
        checkOutput("5a_latency", 32'(firstValidCycle - startCycle), 32'(FRAME_SYMS * BIT_TICKS + 2));
        checkOutput("5a_strobes", 32'(strobeCount), 32'(FRAME_SYMS + 1));
        checkOutput("5a_frame_errors", 32'(frameErrCount), 32'd0);
        checkOutput("5a_erasures", 32'(erasureCount), 32'd0);
        checkOutput("5a_overrun", 32'(overrun), 32'd0);

        // Erasure windows keep the FSM idle, then a frame still aligns
        $display("[TB] erasure windows");
        doReset(32'd0);
        startRun();
        sendWindow(40, 40);
        sendWindow(30, 10);
        checkOutput("erasure_no_valid", 32'(dataValid), 32'd0);
        expQ.push_back(8'hC3);
        applyStimulus(8'hC3, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("erasure_count", 32'(erasureCount), 32'd2);
        checkOutput("erasure_then_frame", 32'(expQ.size()), 32'd0);
        checkOutput("erasure_frame_errors", 32'(frameErrCount), 32'd0);

        // Bad stop bit
        $display("[TB] bad stop 0xA5");
        doReset(32'd0);
        startRun();
        applyStimulus(8'hA5, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("badstop_frame_error", 32'(frameErrCount), 32'd1);
        checkOutput("badstop_no_valid", 32'(dataValid), 32'd0);

        // Overrun with consumer stalled
        $display("[TB] overrun");
        doReset(32'd0);
        dataReady = 1'b0;
        startRun();
        expQ.push_back(8'h11);
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("overrun_data_held", 32'(data), 32'h11);
        checkOutput("overrun_valid_held", 32'(dataValid), 32'd1);
        checkOutput("overrun_flag", 32'(overrun), 32'd1);
        dataReady = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("overrun_valid_drop", 32'(dataValid), 32'd0);
        checkOutput("overrun_popped", 32'(expQ.size()), 32'd0);
        checkOutput("overrun_sticky", 32'(overrun), 32'd1);

        // Counter wrap on f0
        $display("[TB] f0 wrap");
        doReset(32'hFFFF_FFC0);
        startRun();
        expQ.push_back(8'h0F);
        applyStimulus(8'h0F, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("wrap_delivered", 32'(expQ.size()), 32'd0);
        checkOutput("wrap_erasures", 32'(erasureCount), 32'd0);

        // Enable dropped mid-frame loses the partial byte silently
        $display("[TB] enable drop");
        doReset(32'd0);
        startRun();
        sendSymbol(1'b0);
        sendSymbol(1'b1);
        sendSymbol(1'b1);
        enable = 1'b0;
        repeat (5) @(negedge clock);
        startRun();
        expQ.push_back(8'h77);
        applyStimulus(8'h77, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("resync_delivered", 32'(expQ.size()), 32'd0);
        checkOutput("resync_frame_errors", 32'(frameErrCount), 32'd0);

`ifdef FSK_DECODER_PARITY_EN
        // Parity: wrong parity rejected, correct parity accepted
        $display("[TB] parity");
        doReset(32'd0);
        startRun();
        applyStimulus(8'h03, 1'b1, 1'b1);
        repeat (3) @(negedge clock);
        checkOutput("parity_bad_frame_error", 32'(frameErrCount), 32'd1);
        checkOutput("parity_bad_no_valid", 32'(dataValid), 32'd0);
        expQ.push_back(8'h03);
        applyStimulus(8'h03, 1'b1, 1'b0);
        repeat (3) @(negedge clock);
        checkOutput("parity_good_delivered", 32'(expQ.size()), 32'd0);
        checkOutput("parity_good_frame_errors", 32'(frameErrCount), 32'd1);
`endif

        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
